// File: rtl/clock_timekeeper_if.sv
// Button/tick inputs and BCD time-of-day outputs of the timekeeper.
interface clock_timekeeper_if;
    logic       sec_tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic [1:0] mode;
    logic       day_tick;

    // Master drives the pulses and observes the time; slave is the timekeeper.
    modport master (
        output sec_tick, mode_btn, inc_btn,
        input  hours, minutes, seconds, mode, day_tick
    );

    modport slave (
        input  sec_tick, mode_btn, inc_btn,
        output hours, minutes, seconds, mode, day_tick
    );
endinterface

// File: rtl/clock_timekeeper.sv
// Time-of-day keeper: HH:MM:SS in packed BCD, advanced by the 1 Hz tick,
// with a RUN / SET_HOUR / SET_MIN mode machine driven by button pulses.
module clock_timekeeper #(
    parameter logic [7:0] INIT_HH = 8'h00,
    parameter logic [7:0] INIT_MM = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    clock_timekeeper_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } mode_e;

    mode_e      state_q, state_d;
    logic [7:0] hours_q, hours_d;
    logic [7:0] minutes_q, minutes_d;
    logic [7:0] seconds_q, seconds_d;
    logic       day_tick_q, day_tick_d;

    // Packed-BCD increment with 59 -> 00 wrap.
    function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
        if (v == 8'h59) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Packed-BCD increment with 23 -> 00 wrap; the whole field is compared so
    // that 19 -> 20 carries normally and only 23 wraps.
    function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
        if (v == 8'h23) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // State register for the mode machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode machine next state: each mode_btn pulse advances one step.
    always_comb begin
        state_d = state_q;
        if (bus.mode_btn) begin
            unique case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                StSetMin:  state_d = StRun;
                default:   state_d = StRun;
            endcase
        end
    end

    // Time field next state; set modes freeze the tick, mode_btn beats inc_btn.
    always_comb begin
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        day_tick_d = 1'b0;
        unique case (state_q)
            StRun: begin
                // The tick still applies on the edge that leaves RUN.
                if (bus.sec_tick) begin
                    seconds_d = bcd_inc_60(seconds_q);
                    if (seconds_q == 8'h59) begin
                        minutes_d = bcd_inc_60(minutes_q);
                        if (minutes_q == 8'h59) begin
                            hours_d = bcd_inc_24(hours_q);
                            if (hours_q == 8'h23) begin
                                day_tick_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StSetHour: begin
                if (!bus.mode_btn && bus.inc_btn) begin
                    hours_d = bcd_inc_24(hours_q);
                end
            end
            StSetMin: begin
                if (bus.mode_btn) begin
                    seconds_d = 8'h00;
                end else if (bus.inc_btn) begin
                    minutes_d = bcd_inc_60(minutes_q);
                end
            end
            default: begin
                hours_d = hours_q;
            end
        endcase
    end

    // Time field registers; reset discards any partial set.
    always_ff @(posedge clk) begin
        if (reset) begin
            hours_q    <= INIT_HH;
            minutes_q  <= INIT_MM;
            seconds_q  <= 8'h00;
            day_tick_q <= 1'b0;
        end else begin
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            day_tick_q <= day_tick_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.hours    = hours_q;
        bus.minutes  = minutes_q;
        bus.seconds  = seconds_q;
        bus.mode     = state_q;
        bus.day_tick = day_tick_q;
    end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: directed scenarios plus random pulses, checked
// every cycle against a seconds-of-day model.
module tb_clock_timekeeper;

    localparam int InitH = 23;
    localparam int InitM = 59;

    typedef struct {
        int h;
        int m;
        int s;
        int mode;
        bit dt;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    model_t mdl;
    bit     m_valid = 1'b0;

    clock_timekeeper_if tbif ();

    clock_timekeeper #(
        .INIT_HH(8'h23),
        .INIT_MM(8'h59)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tbif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Reference behaviour: RUN works on total seconds of the day.
    function automatic model_t model_next(input model_t c, input bit st, input bit mb,
                                          input bit ib);
        model_t n;
        int t;
        n = c;
        n.dt = 1'b0;
        case (c.mode)
            0: begin
                if (st) begin
                    t = c.h * 3600 + c.m * 60 + c.s;
                    n.dt = (t == 86399);
                    t = (t + 1) % 86400;
                    n.h = t / 3600;
                    n.m = (t / 60) % 60;
                    n.s = t % 60;
                end
                if (mb) n.mode = 1;
            end
            1: begin
                if (mb) n.mode = 2;
                else if (ib) n.h = (c.h + 1) % 24;
            end
            default: begin
                if (mb) begin
                    n.mode = 0;
                    n.s = 0;
                end else if (ib) begin
                    n.m = (c.m + 1) % 60;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mdl <= '{h: InitH, m: InitM, s: 0, mode: 0, dt: 1'b0};
            m_valid <= 1'b1;
        end else if (m_valid) begin
            mdl <= model_next(mdl, tbif.sec_tick, tbif.mode_btn, tbif.inc_btn);
        end
    end

    // Per-cycle comparison against the model, plus BCD legality of every field.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_vs_model",
                {40'd0, tbif.hours, tbif.minutes, tbif.seconds, tbif.mode, tbif.day_tick},
                {40'd0, to_bcd(mdl.h), to_bcd(mdl.m), to_bcd(mdl.s), 2'(mdl.mode), mdl.dt});
            chk("bcd_legal",
                64'((tbif.hours <= 8'h23) && (tbif.hours[3:0] <= 4'd9) &&
                    (tbif.minutes[7:4] <= 4'd5) && (tbif.minutes[3:0] <= 4'd9) &&
                    (tbif.seconds[7:4] <= 4'd5) && (tbif.seconds[3:0] <= 4'd9)),
                64'd1);
        end
    end

    // One clock edge with the given inputs; returns just after that edge.
    task automatic step(input bit r, input bit st, input bit mb, input bit ib);
        @(negedge clk);
        #1;
        reset = r;
        tbif.sec_tick = st;
        tbif.mode_btn = mb;
        tbif.inc_btn = ib;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tbif.sec_tick = 1'b0;
        tbif.mode_btn = 1'b0;
        tbif.inc_btn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    // Set hours and minutes by pressing inc the given number of times.
    task automatic go_set(input int hinc, input int minc);
        step(0, 0, 1, 0);
        for (int i = 0; i < hinc; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < minc; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
    endtask

    logic [7:0] exp_h[5];
    logic [7:0] exp_m[3];

    initial begin
        tbif.sec_tick = 1'b0;
        tbif.mode_btn = 1'b0;
        tbif.inc_btn = 1'b0;
        exp_h = '{8'h22, 8'h23, 8'h00, 8'h01, 8'h02};
        exp_m = '{8'h59, 8'h00, 8'h01};

        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("reset_state", {tbif.hours, tbif.minutes, tbif.seconds, tbif.mode, tbif.day_tick},
            {8'h23, 8'h59, 8'h00, 2'b00, 1'b0});

        // Day rollover.
        ticks(59);
        chk("t1_235959", {tbif.hours, tbif.minutes, tbif.seconds}, 24'h235959);
        ticks(1);
        chk("t1_rollover", {tbif.hours, tbif.minutes, tbif.seconds, tbif.mode, tbif.day_tick},
            {24'h000000, 2'b00, 1'b1});
        step(0, 0, 0, 0);
        chk("t1_day_tick_one_cycle", tbif.day_tick, 1'b0);

        // Tens carries in hours.
        go_set(9, 59);
        ticks(59);
        chk("t2_095959", {tbif.hours, tbif.minutes, tbif.seconds}, 24'h095959);
        ticks(1);
        chk("t2_100000", {tbif.hours, tbif.minutes, tbif.seconds, tbif.day_tick}, {24'h100000, 1'b0});
        go_set(9, 59);
        ticks(59);
        chk("t2_195959", {tbif.hours, tbif.minutes, tbif.seconds}, 24'h195959);
        ticks(1);
        chk("t2_200000", {tbif.hours, tbif.minutes, tbif.seconds}, 24'h200000);

        // Hour setting with wrap; ticks are ignored.
        ticks(7);
        step(0, 0, 1, 0);
        chk("t3_mode_set_hour", tbif.mode, 2'b01);
        step(0, 0, 0, 1);
        chk("t3_hours_21", tbif.hours, 8'h21);
        for (int i = 0; i < 5; i++) begin
            step(0, (i % 2) == 0, 0, 1);
            chk("t3_hours_inc", {tbif.hours, tbif.seconds}, {exp_h[i], 8'h07});
        end
        step(0, 1, 0, 0);
        chk("t3_seconds_frozen", tbif.seconds, 8'h07);

        // Minute setting with wrap and no hour carry; exit clears seconds.
        step(0, 0, 1, 0);
        chk("t4_mode_set_min", tbif.mode, 2'b10);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 1);
        chk("t4_minutes_58", tbif.minutes, 8'h58);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("t4_minutes_inc", {tbif.hours, tbif.minutes}, {8'h02, exp_m[i]});
        end
        step(0, 1, 1, 0);
        chk("t4_exit_run", {tbif.mode, tbif.hours, tbif.minutes, tbif.seconds},
            {2'b00, 24'h020100});

        // Simultaneous inputs.
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("t5_mode_beats_inc", {tbif.mode, tbif.hours}, {2'b10, 8'h02});
        step(0, 0, 1, 0);
        ticks(59);
        chk("t5_020159", {tbif.hours, tbif.minutes, tbif.seconds}, 24'h020159);
        step(0, 1, 1, 0);
        chk("t5_tick_and_mode", {tbif.mode, tbif.hours, tbif.minutes, tbif.seconds},
            {2'b01, 24'h020200});

        // Reset mid-set discards the edit.
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        chk("t6_partial_edit", {tbif.mode, tbif.minutes}, {2'b10, 8'h06});
        step(1, 0, 0, 1);
        chk("t6_reset", {tbif.hours, tbif.minutes, tbif.seconds, tbif.mode, tbif.day_tick},
            {24'h235900, 2'b00, 1'b0});

        // Random pulses; reset occasionally returns to 23:59 for more rollovers.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
